// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - state, opcode and control-field encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JALRADR  = 4'd10,
    JAL      = 4'd11,
    UTYPE    = 4'd12,
    TRAP     = 4'd13
  } state_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_utype(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath control bundle
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic             [6:0] op;
  logic                   funct3_0;
  logic                   zero;
  logic                   mem_ready;
  logic                   pcwrite;
  logic                   adrsrc;
  logic                   memwrite;
  logic                   irwrite;
  logic                   regwrite;
  logic             [1:0] resultsrc;
  logic             [1:0] alusrca;
  logic             [1:0] alusrcb;
  logic             [2:0] immsrc;
  logic             [1:0] aluop;
  logic                   illegal;
  logic                   retire;
  logic       [CNT_W-1:0] instret;

  modport master (
    input  op, funct3_0, zero, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, aluop, illegal, retire, instret
  );

  modport slave (
    output op, funct3_0, zero, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, aluop, illegal, retire, instret
  );
endinterface

// File: rtl/imm_src_decoder.sv
// rtl/imm_src_decoder.sv - combinational opcode to immediate-format decode
module imm_src_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] immsrc_o
);

  always_comb begin
    immsrc_o = IMM_I;
    case (op_i)
      OP_SW:            immsrc_o = IMM_S;
      OP_BRANCH:        immsrc_o = IMM_B;
      OP_JAL:           immsrc_o = IMM_J;
      OP_LUI, OP_AUIPC: immsrc_o = IMM_U;
      default:          immsrc_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle control FSM with memory wait states, trap and instret
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit EN_UTYPE   = 1'b1,
  parameter bit EN_MEMWAIT = 1'b1,
  parameter bit TRAP_HALT  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       rdy;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal, retire;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [2:0] immsrc;

  assign rdy = EN_MEMWAIT ? bus.mem_ready : 1'b1;

  imm_src_decoder u_imm_src_decoder (
    .op_i     (bus.op),
    .immsrc_o (immsrc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    illegal   = 1'b0;
    retire    = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        pcwrite   = rdy;
        irwrite   = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        // Speculatively form oldPC+imm so branch/jal targets are ready in ALUOut
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_IMM:       state_d = EXECUTEI;
          OP_BRANCH:    state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          OP_JALR:      state_d = JALRADR;
          default: begin
            if (EN_UTYPE && is_utype(bus.op)) state_d = UTYPE;
            else                              state_d = TRAP;
          end
        endcase
      end
      MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        resultsrc = RES_RDATA;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = rdy;
        if (rdy) state_d = FETCH;
      end
      EXECUTER: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        resultsrc = RES_ALUOUT;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_SUB;
        resultsrc = RES_ALUOUT;
        pcwrite   = bus.zero ^ bus.funct3_0;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JALRADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        state_d = JAL;
      end
      JAL: begin
        // PC takes the target already in ALUOut while the ALU forms the link value
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALUOUT;
        pcwrite   = 1'b1;
        state_d   = ALUWB;
      end
      UTYPE: begin
        alusrca = (bus.op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        state_d = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP_HALT ? TRAP : FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      retire   = 1'b0;
      state_d  = FETCH;
    end
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  assign bus.pcwrite   = pcwrite;
  assign bus.adrsrc    = adrsrc;
  assign bus.memwrite  = memwrite;
  assign bus.irwrite   = irwrite;
  assign bus.regwrite  = regwrite;
  assign bus.resultsrc = resultsrc;
  assign bus.alusrca   = alusrca;
  assign bus.alusrcb   = alusrcb;
  assign bus.immsrc    = immsrc;
  assign bus.aluop     = aluop;
  assign bus.illegal   = illegal;
  assign bus.retire    = retire;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench over three parameterisations of multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef struct {
    int          d;
    logic        r;
    logic [6:0]  op;
    logic        f3;
    logic        z;
    logic        rdy;
    logic [17:0] ev;
    logic [31:0] ec;
    logic [63:0] tag;
  } ent_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks;
  int   errors;
  int unsigned cnt [3];
  ent_t q [$];

  multicycle_controller_if #(.CNT_W(32)) ifa ();
  multicycle_controller_if #(.CNT_W(32)) ifb ();
  multicycle_controller_if #(.CNT_W(32)) ifc ();

  multicycle_controller #(.EN_UTYPE(1'b1), .EN_MEMWAIT(1'b1), .TRAP_HALT(1'b1), .CNT_W(32)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  multicycle_controller #(.EN_UTYPE(1'b0), .EN_MEMWAIT(1'b0), .TRAP_HALT(1'b1), .CNT_W(32)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );
  multicycle_controller #(.EN_UTYPE(1'b0), .EN_MEMWAIT(1'b1), .TRAP_HALT(1'b0), .CNT_W(32)) dut_c (
    .clk (clk), .rst (rst_c), .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, immsrc, aluop, illegal, retire}
  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [2:0] im, input logic [1:0] aop,
                                     input logic ill, input logic ret);
    return {pcw, adr, mw, irw, rw, rs, asa, asb, im, aop, ill, ret};
  endfunction

  task automatic put(input int d, input logic r, input logic [6:0] op, input logic f3,
                     input logic z, input logic rdy, input logic [17:0] ev, input logic [63:0] tag);
    ent_t e;
    e.d = d; e.r = r; e.op = op; e.f3 = f3; e.z = z; e.rdy = rdy;
    e.ev = ev; e.ec = cnt[d]; e.tag = tag;
    q.push_back(e);
    if (r)          cnt[d] = 0;
    else if (ev[0]) cnt[d] = cnt[d] + 1;
  endtask

  task automatic fetch_dec(input int d, input logic [6:0] op, input logic f3, input logic z,
                           input logic [2:0] im, input logic rdy);
    put(d, 1'b0, op, f3, z, rdy, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, 2'b00, 0, 0), "fetch");
    put(d, 1'b0, op, f3, z, 1'b0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 2'b00, 0, 0), "decode");
  endtask

  task automatic run();
    ent_t        e;
    logic [17:0] obs;
    logic [31:0] cobs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.d)
        0: begin rst_a = e.r; ifa.op = e.op; ifa.funct3_0 = e.f3; ifa.zero = e.z; ifa.mem_ready = e.rdy; end
        1: begin rst_b = e.r; ifb.op = e.op; ifb.funct3_0 = e.f3; ifb.zero = e.z; ifb.mem_ready = e.rdy; end
        default: begin rst_c = e.r; ifc.op = e.op; ifc.funct3_0 = e.f3; ifc.zero = e.z; ifc.mem_ready = e.rdy; end
      endcase
      #1;
      case (e.d)
        0: begin
          obs = {ifa.pcwrite, ifa.adrsrc, ifa.memwrite, ifa.irwrite, ifa.regwrite, ifa.resultsrc,
                 ifa.alusrca, ifa.alusrcb, ifa.immsrc, ifa.aluop, ifa.illegal, ifa.retire};
          cobs = ifa.instret;
        end
        1: begin
          obs = {ifb.pcwrite, ifb.adrsrc, ifb.memwrite, ifb.irwrite, ifb.regwrite, ifb.resultsrc,
                 ifb.alusrca, ifb.alusrcb, ifb.immsrc, ifb.aluop, ifb.illegal, ifb.retire};
          cobs = ifb.instret;
        end
        default: begin
          obs = {ifc.pcwrite, ifc.adrsrc, ifc.memwrite, ifc.irwrite, ifc.regwrite, ifc.resultsrc,
                 ifc.alusrca, ifc.alusrcb, ifc.immsrc, ifc.aluop, ifc.illegal, ifc.retire};
          cobs = ifc.instret;
        end
      endcase
      checks++;
      assert (obs === e.ev) else begin
        errors++;
        $error("FAIL %s dut%0d outputs obs=%h exp=%h", e.tag, e.d, obs, e.ev);
      end
      checks++;
      assert (cobs === e.ec) else begin
        errors++;
        $error("FAIL %s dut%0d instret obs=%0d exp=%0d", e.tag, e.d, cobs, e.ec);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.op = '0; ifa.funct3_0 = 1'b0; ifa.zero = 1'b0; ifa.mem_ready = 1'b0;
    ifb.op = '0; ifb.funct3_0 = 1'b0; ifb.zero = 1'b0; ifb.mem_ready = 1'b0;
    ifc.op = '0; ifc.funct3_0 = 1'b0; ifc.zero = 1'b0; ifc.mem_ready = 1'b0;
    @(negedge clk);

    // dut_a: reset state, then lw with wait states (10 cycles)
    put(0, 1, LW, 0, 0, 1, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 2'b00, 0, 0), "rst");
    put(0, 0, LW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 2'b00, 0, 0), "lw_fw1");
    put(0, 0, LW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 2'b00, 0, 0), "lw_fw2");
    fetch_dec(0, LW, 0, 0, 3'd0, 1);
    put(0, 0, LW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 2'b00, 0, 0), "lw_madr");
    for (int i = 0; i < 3; i++)
      put(0, 0, LW, 0, 0, 0, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0, 0), "lw_rdw");
    put(0, 0, LW, 0, 0, 1, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0, 0), "lw_rd");
    put(0, 0, LW, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1), "lw_wb");

    // beq taken, bne not taken
    fetch_dec(0, BR, 0, 1, 3'd2, 1);
    put(0, 0, BR, 0, 1, 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd2, 2'b01, 0, 1), "beq");
    fetch_dec(0, BR, 1, 1, 3'd2, 1);
    put(0, 0, BR, 1, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd2, 2'b01, 0, 1), "bne");

    // jalr
    fetch_dec(0, JALR, 0, 0, 3'd0, 1);
    put(0, 0, JALR, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 2'b00, 0, 0), "jalradr");
    put(0, 0, JALR, 0, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 2'b00, 0, 0), "jal");
    put(0, 0, JALR, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1), "jal_wb");

    // auipc and lui with U-type enabled
    fetch_dec(0, AUIPC, 0, 0, 3'd4, 1);
    put(0, 0, AUIPC, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd4, 2'b00, 0, 0), "auipc");
    put(0, 0, AUIPC, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd4, 2'b00, 0, 1), "auipc_wb");
    fetch_dec(0, LUI, 0, 0, 3'd4, 1);
    put(0, 0, LUI, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'd4, 2'b00, 0, 0), "lui");
    put(0, 0, LUI, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd4, 2'b00, 0, 1), "lui_wb");

    // sw with one wait cycle
    fetch_dec(0, SW, 0, 0, 3'd1, 1);
    put(0, 0, SW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd1, 2'b00, 0, 0), "sw_madr");
    put(0, 0, SW, 0, 0, 0, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 2'b00, 0, 0), "sw_wait");
    put(0, 0, SW, 0, 0, 1, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 2'b00, 0, 1), "sw_done");

    // sw interrupted by reset in its 2nd MEMWRITE cycle
    fetch_dec(0, SW, 0, 0, 3'd1, 1);
    put(0, 0, SW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd1, 2'b00, 0, 0), "sw_madr");
    put(0, 0, SW, 0, 0, 0, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 2'b00, 0, 0), "sw_wait");
    put(0, 1, SW, 0, 0, 0, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd1, 2'b00, 0, 0), "sw_rst");
    put(0, 0, SW, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd1, 2'b00, 0, 0), "post_rst");
    run();

    // dut_b: no memory wait, U-type illegal, trap halts
    put(1, 1, ADD, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 2'b00, 0, 0), "b_rst");
    fetch_dec(1, ADD, 0, 0, 3'd0, 0);
    put(1, 0, ADD, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd0, 2'b10, 0, 0), "exec_r");
    put(1, 0, ADD, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1), "add_wb");
    fetch_dec(1, LUI, 0, 0, 3'd4, 0);
    for (int i = 0; i < 20; i++)
      put(1, 0, LUI, 0, 0, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd4, 2'b00, 1, 0), "trap_h");
    run();

    // dut_c: trap releases to FETCH after one cycle
    put(2, 1, LUI, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd4, 2'b00, 0, 0), "c_rst");
    fetch_dec(2, LUI, 0, 0, 3'd4, 1);
    put(2, 0, LUI, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd4, 2'b00, 1, 0), "trap_1");
    put(2, 0, LUI, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd4, 2'b00, 0, 0), "trap_ret");
    put(2, 0, LUI, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd4, 2'b00, 0, 0), "f_hold");
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core. It replaces the single-cycle opcode decode with a registered state machine.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds memory wait-state handshaking, optional U-type support, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- EN_UTYPE, 1, 1 = decode lui (0110111) and auipc (0010111); 0 = both are illegal.
- EN_MEMWAIT, 1, 1 = FETCH, MEMREAD and MEMWRITE wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- TRAP_HALT, 1, 1 = TRAP is terminal until reset; 0 = TRAP returns to FETCH after one cycle.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- op  in  7  opcode from the instruction register
- funct3_0  in  1  instr[12]; 0 = beq, 1 = bne
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcwrite  out  1  PC load enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR and oldPC load enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alusrcb  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- immsrc  out  3  immediate format: I 000, S 001, B 010, J 011, U 100
- aluop  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- illegal  out  1  high while in TRAP
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Outputs are Moore functions of the state register, except that pcwrite, irwrite, memwrite, retire and state advance are additionally gated by mem_ready and zero as listed below.
- immsrc is decoded combinationally from op alone: lw/op-imm/jalr 000, sw 001, branch 010, jal 011, lui/auipc 100, all others 000.
- Reset: state = FETCH, instret = 0. While rst = 1, pcwrite, irwrite, regwrite, memwrite and retire are forced to 0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcwrite assert only in the cycle mem_ready=1; that cycle moves the FSM to DECODE. Otherwise stay in FETCH.
- DECODE: alusrca=01, alusrcb=01 (ALUOut <- oldPC+imm). Next state by op:
  - lw/sw -> MEMADR
  - R-type -> EXECUTER
  - op-imm -> EXECUTEI
  - branch -> BRANCH
  - jal -> JAL
  - jalr -> JALRADR
  - lui/auipc with EN_UTYPE=1 -> UTYPE
  - anything else, including 0000000 -> TRAP
- MEMADR: alusrca=10, alusrcb=01. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: adrsrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: resultsrc=01, regwrite=1, retire=1 -> FETCH.
- MEMWRITE:
  - adrsrc=1, memwrite held at 1 until mem_ready.
  - The ready cycle asserts retire and moves to FETCH. memwrite must not drop before mem_ready.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
- ALUWB: resultsrc=00, regwrite=1, retire=1 -> FETCH.
- BRANCH:
  - alusrca=10, alusrcb=00, aluop=01, resultsrc=00.
  - pcwrite = zero XOR funct3_0.
  - retire=1 -> FETCH.
- JALRADR: alusrca=10, alusrcb=01 (ALUOut <- rs1+imm) -> JAL.
- JAL:
  - alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1 (PC <- ALUOut).
  - ALUOut <- oldPC+4 -> ALUWB, which performs the link write and the retire.
- UTYPE: alusrca=11 for lui, 01 for auipc; alusrcb=01 -> ALUWB.
- TRAP: illegal=1, no enables asserted, no retire. TRAP_HALT=1: stay until rst. TRAP_HALT=0: go to FETCH next cycle.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- rst mid-instruction, including MEMWRITE waiting on mem_ready: the next cycle is FETCH, with no partial regwrite and no retire.

Decomposition:
- Package mc_pkg holds:
  - the state enum, 4-bit encodings FETCH=0 through TRAP=13
  - opcode constants
  - alusrca, alusrcb, resultsrc, immsrc and aluop encodings
- Sub-module imm_src_decoder: combinational op -> immsrc, reused by the pipelined core.

Test Plan:
- lw, mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> irwrite a single pulse; regwrite=1 exactly once in MEMWB; 10 cycles total; instret 0 -> 1.
- add (0110011), EN_MEMWAIT=0 -> FETCH, DECODE, EXECUTER, ALUWB in 4 cycles; aluop=10 in EXECUTER; retire in ALUWB.
- beq zero=1, then bne zero=1 -> pcwrite=1 in BRANCH for beq; pcwrite=0 for bne; both retire.
- jalr (1100111) -> FETCH, DECODE, JALRADR, JAL, ALUWB; pcwrite=1 in JAL; regwrite=1 in ALUWB.
- lui with EN_UTYPE=0 and TRAP_HALT=1 -> TRAP; illegal held 20 cycles; instret unchanged. Same with TRAP_HALT=0 -> illegal for 1 cycle, then FETCH.
- sw with mem_ready low; assert rst in the 2nd MEMWRITE cycle -> memwrite=0 during rst; FETCH next cycle; instret=0.
